// File: rtl/universal_register.sv
// rtl/universal_register.sv - multi-mode register: load/shift/rotate/inc/dec with carry and zero flags
// Optional shadow capture register enabled by defining UNIREG_SHADOW_EN.
module universal_register #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] SET_VALUE = {WIDTH{1'b1}}
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_set,
    input  logic             i_en,
    input  logic [2:0]       i_mode,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_sin,
`ifdef UNIREG_SHADOW_EN
    input  logic             i_cap,
    output logic [WIDTH-1:0] o_shadow,
`endif
    output logic [WIDTH-1:0] o_q,
    output logic             o_carry,
    output logic             o_zero
);

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_SHR  = 3'b011,
        MODE_ROL  = 3'b100,
        MODE_ROR  = 3'b101,
        MODE_INC  = 3'b110,
        MODE_DEC  = 3'b111
    } mode_t;

    mode_t          mode;
    logic [WIDTH:0] inc_sum;

    assign mode    = mode_t'(i_mode);
    assign inc_sum = {1'b0, o_q} + {{WIDTH{1'b0}}, 1'b1};
    assign o_zero  = (o_q == '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_q     <= '0;
            o_carry <= 1'b0;
        end else if (i_set) begin
            o_q     <= SET_VALUE;
            o_carry <= 1'b0;
        end else if (i_en) begin
            case (mode)
                MODE_LOAD: begin
                    o_q     <= i_d;
                    o_carry <= 1'b0;
                end
                MODE_SHL: begin
                    o_q     <= {o_q[WIDTH-2:0], i_sin};
                    o_carry <= o_q[WIDTH-1];
                end
                MODE_SHR: begin
                    o_q     <= {i_sin, o_q[WIDTH-1:1]};
                    o_carry <= o_q[0];
                end
                MODE_ROL: begin
                    o_q     <= {o_q[WIDTH-2:0], o_q[WIDTH-1]};
                    o_carry <= o_q[WIDTH-1];
                end
                MODE_ROR: begin
                    o_q     <= {o_q[0], o_q[WIDTH-1:1]};
                    o_carry <= o_q[0];
                end
                MODE_INC: begin
                    o_q     <= inc_sum[WIDTH-1:0];
                    o_carry <= inc_sum[WIDTH];
                end
                MODE_DEC: begin
                    // borrow out is exactly the underflow from zero
                    o_q     <= o_q - {{(WIDTH-1){1'b0}}, 1'b1};
                    o_carry <= (o_q == '0);
                end
                default: begin
                    o_q     <= o_q;
                    o_carry <= o_carry;
                end
            endcase
        end
    end

`ifdef UNIREG_SHADOW_EN
    // captures the pre-update value; unaffected by set or enable
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_shadow <= '0;
        end else if (i_cap) begin
            o_shadow <= o_q;
        end
    end
`endif

endmodule

// File: tb/tb_universal_register.sv
// tb/tb_universal_register.sv - directed self-checking bench for universal_register
module tb_universal_register;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, set, en, sin;
    logic [2:0]   mode;
    logic [W-1:0] d;
    logic [W-1:0] q0, q1;
    logic         carry0, carry1, zero0, zero1;
`ifdef UNIREG_SHADOW_EN
    logic         cap;
    logic [W-1:0] shadow0, shadow1;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    universal_register #(.WIDTH(W), .SET_VALUE(8'h3C)) u_reg_3c (
        .i_clk(clk), .i_rst(rst), .i_set(set), .i_en(en), .i_mode(mode),
        .i_d(d), .i_sin(sin),
`ifdef UNIREG_SHADOW_EN
        .i_cap(cap), .o_shadow(shadow0),
`endif
        .o_q(q0), .o_carry(carry0), .o_zero(zero0)
    );

    universal_register #(.WIDTH(W)) u_reg_def (
        .i_clk(clk), .i_rst(rst), .i_set(set), .i_en(en), .i_mode(mode),
        .i_d(d), .i_sin(sin),
`ifdef UNIREG_SHADOW_EN
        .i_cap(cap), .o_shadow(shadow1),
`endif
        .o_q(q1), .o_carry(carry1), .o_zero(zero1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [2:0] m, input logic [W-1:0] dv, input logic s);
        en = 1'b1; mode = m; d = dv; sin = s;
        step();
    endtask

    initial begin
        rst = 1'b1; set = 1'b1; en = 1'b0; mode = 3'b000; d = 8'hA5; sin = 1'b0;
`ifdef UNIREG_SHADOW_EN
        cap = 1'b0;
`endif
        step(); step();
        check("rst_q", q0, 8'h00);
        check("rst_carry", carry0, 1'b0);
        check("rst_zero", zero0, 1'b1);
        check("rst_q_def", q1, 8'h00);

        rst = 1'b0; set = 1'b1; en = 1'b0;
        step();
        check("set_q_3c", q0, 8'h3C);
        check("set_q_def", q1, 8'hFF);
        check("set_carry", carry0, 1'b0);
        set = 1'b0;

        op(3'b001, 8'h81, 1'b0);
        check("load_81", q0, 8'h81);
        check("load_carry", carry0, 1'b0);
        op(3'b100, 8'h00, 1'b0);
        check("rol_q", q0, 8'h03);
        check("rol_carry", carry0, 1'b1);

        op(3'b001, 8'hFE, 1'b0);
        op(3'b110, 8'h00, 1'b0);
        check("inc1_q", q0, 8'hFF);
        check("inc1_carry", carry0, 1'b0);
        check("inc1_zero", zero0, 1'b0);
        op(3'b110, 8'h00, 1'b0);
        check("inc2_q", q0, 8'h00);
        check("inc2_carry", carry0, 1'b1);
        check("inc2_zero", zero0, 1'b1);
        op(3'b111, 8'h00, 1'b0);
        check("dec_wrap_q", q0, 8'hFF);
        check("dec_wrap_carry", carry0, 1'b1);
        op(3'b000, 8'h00, 1'b1);
        check("hold_q", q0, 8'hFF);
        check("hold_carry", carry0, 1'b1);
        op(3'b111, 8'h00, 1'b0);
        check("dec_q", q0, 8'hFE);
        check("dec_carry", carry0, 1'b0);

        op(3'b001, 8'hB2, 1'b0);
        op(3'b011, 8'h00, 1'b1);
        check("shr_q", q0, 8'hD9);
        check("shr_carry", carry0, 1'b0);
        op(3'b010, 8'h00, 1'b0);
        check("shl_q", q0, 8'hB2);
        check("shl_carry", carry0, 1'b1);

        op(3'b001, 8'h01, 1'b0);
        op(3'b101, 8'h00, 1'b0);
        check("ror_q", q0, 8'h80);
        check("ror_carry", carry0, 1'b1);

        rst = 1'b1; set = 1'b1; en = 1'b1; mode = 3'b001; d = 8'h55;
        step();
        check("prio_rst_q", q1, 8'h00);
        check("prio_rst_carry", carry1, 1'b0);
        rst = 1'b0;
        step();
        check("prio_set_q_def", q1, 8'hFF);
        check("prio_set_q_3c", q0, 8'h3C);
        set = 1'b0; en = 1'b0; mode = 3'b110;
        step();
        check("en_low_q", q1, 8'hFF);
        check("en_low_carry", carry1, 1'b0);

        op(3'b110, 8'h00, 1'b0);
        check("run_inc_q", q1, 8'h00);
        check("run_inc_carry", carry1, 1'b1);
        rst = 1'b1;
        op(3'b110, 8'h00, 1'b0);
        check("mid_rst_q", q1, 8'h00);
        check("mid_rst_carry", carry1, 1'b0);
        rst = 1'b0;

`ifdef UNIREG_SHADOW_EN
        op(3'b001, 8'h12, 1'b0);
        cap = 1'b1;
        op(3'b110, 8'h00, 1'b0);
        check("shadow_cap", shadow0, 8'h12);
        check("shadow_q", q0, 8'h13);
        cap = 1'b0; set = 1'b1;
        step();
        check("shadow_set_keep", shadow0, 8'h12);
        set = 1'b0; rst = 1'b1;
        step();
        check("shadow_rst", shadow0, 8'h00);
        rst = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
